alu_serial: RTL and testbench



---
 rtl/alu_serial.sv | 151 +++++++++++++++
 tb/tb_alu_serial.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// Bit-serial ALU: one AND/OR/ADD/SLT slice per clock, LSB first, with the carry
// rippled through a register; start/done handshake and registered flags.
module alu_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             binv,
  input  logic [1:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int                IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [1:0]        SEL_AND  = 2'b00;
  localparam logic [1:0]        SEL_OR   = 2'b01;
  localparam logic [1:0]        SEL_SLT  = 2'b11;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             co_q, co_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       sel_q, sel_d;
  logic             binv_q, binv_d;
  logic [WIDTH-1:0] sr_q, sr_d;

  logic             bb, slice_bit, slice_cout, load, arith, ovf_fin;
  logic [WIDTH-1:0] final_res;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    co_d     = co_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    sr_d     = sr_q;
    load     = 1'b0;

    bb         = b_q[idx_q] ^ binv_q;
    slice_cout = (a_q[idx_q] & bb) | (a_q[idx_q] & carry_q) | (bb & carry_q);
    case (sel_q)
      SEL_AND: slice_bit = a_q[idx_q] & bb;
      SEL_OR:  slice_bit = a_q[idx_q] | bb;
      default: slice_bit = a_q[idx_q] ^ bb ^ carry_q;
    endcase

    // carry_q holds the carry into the MSB while the last slice is evaluated
    arith     = sel_q[1];
    ovf_fin   = arith & (carry_q ^ slice_cout);
    final_res = {slice_bit, sr_q[WIDTH-1:1]};
    if (sel_q == SEL_SLT) begin
      final_res    = '0;
      final_res[0] = slice_bit ^ ovf_fin;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sr_d    = {slice_bit, sr_q[WIDTH-1:1]};
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d  = DONE;
          idx_d    = '0;
          result_d = final_res;
          co_d     = arith & slice_cout;
          ovf_d    = ovf_fin;
          zero_d   = (final_res == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      carry_d = binv | (sel == SEL_SLT);
      idx_d   = '0;
    end

    a_d    = load ? a : a_q;
    b_d    = load ? b : b_q;
    sel_d  = load ? sel : sel_q;
    binv_d = load ? (binv | (sel == SEL_SLT)) : binv_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      co_q     <= co_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  // Operand and partial-sum registers carry no reset; they are only observed after a load
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    sel_q  <= sel_d;
    binv_q <= binv_d;
    sr_q   <= sr_d;
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign co       = co_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed-vector bench for alu_serial at WIDTH=8 with hand-computed expectations.
module tb_alu_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         binv = 1'b0;
  logic [1:0]   sel = 2'b00;
  logic         busy, done, co, zero, overflow;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  alu_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .binv(binv),
    .sel(sel), .busy(busy), .done(done), .result(result), .co(co),
    .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Counts negedges after the start edge until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [1:0] ts, input logic tbinv, input logic [W-1:0] e_res,
                       input logic e_co, input logic e_zero, input logic e_ovf);
    int lat;
    @(negedge clk);
    a = ta; b = tb; sel = ts; binv = tbinv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_res"}, result, e_res);
    chk({tag, "_co"}, co, e_co);
    chk({tag, "_zero"}, zero, e_zero);
    chk({tag, "_ovf"}, overflow, e_ovf);
    @(negedge clk);
    chk({tag, "_done_w"}, done, 0);
  endtask

  initial begin
    int n;
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_co", co, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    do_op("add",   8'h7F, 8'h01, 2'b10, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    do_op("sub0",  8'h05, 8'h05, 2'b10, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    do_op("subov", 8'h80, 8'h01, 2'b10, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1);
    do_op("slt1",  8'hFF, 8'h01, 2'b11, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    do_op("slt0",  8'h01, 8'hFF, 2'b11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    do_op("and",   8'hF0, 8'h30, 2'b00, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    do_op("or",    8'h0F, 8'h30, 2'b01, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held high, operands changed after the first result
    @(negedge clk);
    a = 8'h03; b = 8'h04; sel = 2'b10; binv = 1'b0; start = 1'b1;
    wait_done(n);
    chk("b2b_res1", result, 8'h07);
    a = 8'h10; b = 8'h20;
    wait_done(n);
    chk("b2b_gap1", n, 9);
    chk("b2b_res2", result, 8'h30);
    a = 8'h01; b = 8'h01;
    wait_done(n);
    chk("b2b_gap2", n, 9);
    chk("b2b_res3", result, 8'h02);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_idle", busy, 0);

    // Start pulse with other operands during RUN is ignored
    @(negedge clk);
    a = 8'h11; b = 8'h22; sel = 2'b10; binv = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    a = 8'h55; b = 8'h0F; sel = 2'b01; binv = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_held", result, 8'h02);
    lat = 4;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", lat, 9);
    chk("ign_res", result, 8'h33);
    @(negedge clk);
    chk("ign_idle", busy, 0);

    // Reset during RUN aborts the operation
    @(negedge clk);
    a = 8'h40; b = 8'h40; sel = 2'b10; binv = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_res", result, 0);
    chk("mid_zero", zero, 1);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("mid_nodone", n, 0);
    do_op("post", 8'h20, 8'h22, 2'b10, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
